execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 16-bit five-stage pipeline. Sits directly upstream of the memory stage and drives its M-side inputs (regWriteM, memWriteM, aluResM, writeDataM, PCPlus2M, RdM, resultSrcM) through an EX/MEM pipeline register.
- Contains operand forwarding muxes, a single-cycle ALU, branch/jump resolution, and an iterative multi-cycle MUL/DIV/REM unit. While that unit runs, the block stalls the front end.

Parameters:
- DATA_W, 16, datapath width; only 16 is supported.
- RA_W, 4, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- regWriteE, memWriteE  in  1 each  control from ID/EX
- resultSrcE  in  2  writeback select, passed through
- aluCtrlE  in  4  ALU operation
- aluSrcE  in  1  0 = srcB is forwarded rd2; 1 = srcB is immExtE
- branchE, jumpE  in  1 each  branch-if-equal / unconditional jump
- rd1E, rd2E, immExtE, PCE, PCPlus2E  in  16 each  operands and PCs
- RdE  in  4  destination register
- fwdAE, fwdBE  in  2 each  forwarding select: 00 = rdxE, 01 = resultW, 10 = aluResM, 11 = rdxE
- resultW  in  16  writeback result for forwarding
- flushE  in  1  synchronous kill of the current EX instruction
- regWriteM, memWriteM  out  1 each  EX/MEM register outputs
- resultSrcM  out  2  EX/MEM register output
- aluResM, writeDataM, PCPlus2M  out  16 each  EX/MEM register outputs
- RdM  out  4  EX/MEM register output
- PCSrcE  out  1  combinational: jumpE | (branchE & zeroE)
- PCTargetE  out  16  combinational: PCE + immExtE, mod 2^16
- busyE  out  1  combinational stall request to the hazard unit

Behaviour:
- Reset (async): all EX/MEM outputs 0, MUL/DIV FSM to IDLE, counter 0. busyE, PCSrcE and PCTargetE follow their combinational definitions.
- srcA = fwdAE-selected value. fwdB = fwdBE-selected value. srcB = aluSrcE ? immExtE : fwdB. writeDataM captures fwdB.
- aluCtrlE encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA, all using srcB[3:0]
  - 1000 SLT (signed; result 1 or 0)
  - 1001 MUL (low 16 bits), 1010 DIVU, 1011 REMU
  - 1100 PASSB
  - 1101-1111 give 0
  - All arithmetic is mod 2^16.
- zeroE = (srcA - srcB) == 0, independent of aluCtrlE.
- Single-cycle ops: EX/MEM register captures on the next rising edge, so latency is 1 cycle.
- MUL/DIV FSM states IDLE, RUN, DONE:
  - IDLE with aluCtrlE in 1001-1011 and !flushE: busyE=1. Latch srcA, srcB, op and control fields; counter=0; go to RUN. The EX/MEM register loads a bubble (regWriteM=0, memWriteM=0, other fields don't-care but deterministic).
  - RUN: one shift-add (MUL) or restoring-division step per cycle. busyE=1 and bubbles are inserted. When counter==15, go to DONE.
  - DONE: busyE=0. EX/MEM captures the result with the latched control fields. Next state is IDLE unconditionally, so there is no restart on the same op.
  - Total occupancy is 18 cycles.
- Operands are latched at start because aluResM becomes a bubble during the stall. Later changes on the forwarding inputs are ignored.
- Divide by zero: DIVU yields 0xFFFF and REMU yields the dividend, with the same 18-cycle timing.
- flushE:
  - Any state: the next EX/MEM load is a bubble.
  - In RUN or DONE: the operation is aborted, the FSM returns to IDLE, and no result is written.
  - Takes priority over starting a new op.
- Upstream holds E inputs stable while busyE=1. PCSrcE is computed from the live inputs every cycle.
- Async reset mid-RUN: immediate IDLE and bubble outputs.

Optional Feature:
- Macro EXEC_MULDIV_EN.
- Defined: the MUL/DIV FSM is built as described above.
- Undefined: no FSM, busyE tied to 0, aluCtrlE 1001-1011 give result 0 in a single cycle.

Test Plan:
- Reset release, then ADD rd1E=0x1234, rd2E=0x1111, fwd=00, aluSrcE=0, RdE=3, regWriteE=1 -> next edge aluResM=0x2345, RdM=3, regWriteM=1.
- BEQ with branchE=1, rd1E=rd2E=0x00AA, PCE=0x0010, immExtE=0xFFF0 -> PCSrcE=1, PCTargetE=0x0000. Repeat with rd2E=0x00AB -> PCSrcE=0.
- Forwarding: prior ADD puts aluResM=0x2345; next SUB with fwdAE=10, rd2E=0x0345 -> aluResM=0x2000. Again with fwdBE=01, resultW=0x0001, fwdAE=00, rd1E=0x0005 -> 0x0004.
- MUL 0x0123 × 0x0010 (EXEC_MULDIV_EN) -> busyE high 17 cycles, 17 bubbles, then aluResM=0x1230 with latched RdM. DIVU 100/7 -> 14; REMU -> 2; DIVU 0x55/0 -> 0xFFFF.
- flushE asserted in RUN cycle 5 -> busyE drops on the next cycle, no result written, and a subsequent ADD completes normally.
- rst asserted in RUN cycle 8 -> all M outputs 0 immediately, FSM IDLE. After release, a MUL takes the full 18 cycles.

Source files
------------

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, single-cycle ALU, branch/jump resolution and EX/MEM register.
// Optional iterative MUL/DIVU/REMU unit, built only when EXEC_MULDIV_EN is defined.
module execute_stage #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWriteE,
  input  logic              memWriteE,
  input  logic [1:0]        resultSrcE,
  input  logic [3:0]        aluCtrlE,
  input  logic              aluSrcE,
  input  logic              branchE,
  input  logic              jumpE,
  input  logic [DATA_W-1:0] rd1E,
  input  logic [DATA_W-1:0] rd2E,
  input  logic [DATA_W-1:0] immExtE,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus2E,
  input  logic [RA_W-1:0]   RdE,
  input  logic [1:0]        fwdAE,
  input  logic [1:0]        fwdBE,
  input  logic [DATA_W-1:0] resultW,
  input  logic              flushE,
  output logic              regWriteM,
  output logic              memWriteM,
  output logic [1:0]        resultSrcM,
  output logic [DATA_W-1:0] aluResM,
  output logic [DATA_W-1:0] writeDataM,
  output logic [DATA_W-1:0] PCPlus2M,
  output logic [RA_W-1:0]   RdM,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              busyE
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
  localparam logic [3:0] OP_PASSB = 4'b1100;

  logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_res, diff;
  logic              zero_e, busy;

  logic              md_done, md_rw, md_mw;
  logic [1:0]        md_rs;
  logic [RA_W-1:0]   md_rd;
  logic [DATA_W-1:0] md_res, md_pc2, md_wd;

  always_comb begin
    case (fwdAE)
      2'b01:   src_a = resultW;
      2'b10:   src_a = aluResM;
      default: src_a = rd1E;
    endcase
    case (fwdBE)
      2'b01:   fwd_b = resultW;
      2'b10:   fwd_b = aluResM;
      default: fwd_b = rd2E;
    endcase
  end

  assign src_b     = aluSrcE ? immExtE : fwd_b;
  assign diff      = src_a - src_b;
  assign zero_e    = (diff == '0);
  assign PCSrcE    = jumpE | (branchE & zero_e);
  assign PCTargetE = PCE + immExtE;
  assign busyE     = busy;

  // MUL/DIV codes fall into the default: they produce 0 on the single-cycle path
  always_comb begin
    alu_res = '0;
    case (aluCtrlE)
      OP_ADD:   alu_res = src_a + src_b;
      OP_SUB:   alu_res = diff;
      OP_AND:   alu_res = src_a & src_b;
      OP_OR:    alu_res = src_a | src_b;
      OP_XOR:   alu_res = src_a ^ src_b;
      OP_SLL:   alu_res = src_a << src_b[3:0];
      OP_SRL:   alu_res = src_a >> src_b[3:0];
      OP_SRA:   alu_res = $unsigned($signed(src_a) >>> src_b[3:0]);
      OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_PASSB: alu_res = src_b;
      default:  alu_res = '0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;
  localparam logic [1:0] MD_MUL  = 2'b01;
  localparam logic [1:0] MD_DIVU = 2'b10;

  md_state_t         state_q;
  logic [3:0]        cnt_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q, acc_q;
  logic              lat_rw_q, lat_mw_q;
  logic [1:0]        lat_rs_q;
  logic [RA_W-1:0]   lat_rd_q;
  logic [DATA_W-1:0] lat_pc2_q, lat_wd_q;
  logic              is_md, md_start;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W-1:0] rem_diff;

  assign is_md     = (aluCtrlE == OP_MUL) || (aluCtrlE == OP_DIVU) || (aluCtrlE == OP_REMU);
  assign md_start  = (state_q == IDLE) && is_md && !flushE;
  assign busy      = md_start || (state_q == RUN);
  assign md_done   = (state_q == DONE);
  // Division: a_q shifts the dividend out and collects quotient bits, acc_q is the remainder
  assign rem_shift = {acc_q, a_q[DATA_W-1]};
  assign rem_diff  = rem_shift[DATA_W-1:0] - b_q;
  assign md_res    = (op_q == MD_DIVU) ? a_q : acc_q;
  assign md_rw     = lat_rw_q;
  assign md_mw     = lat_mw_q;
  assign md_rs     = lat_rs_q;
  assign md_rd     = lat_rd_q;
  assign md_pc2    = lat_pc2_q;
  assign md_wd     = lat_wd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      lat_rw_q  <= 1'b0;
      lat_mw_q  <= 1'b0;
      lat_rs_q  <= '0;
      lat_rd_q  <= '0;
      lat_pc2_q <= '0;
      lat_wd_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            op_q      <= aluCtrlE[1:0];
            a_q       <= src_a;
            b_q       <= src_b;
            acc_q     <= '0;
            lat_rw_q  <= regWriteE;
            lat_mw_q  <= memWriteE;
            lat_rs_q  <= resultSrcE;
            lat_rd_q  <= RdE;
            lat_pc2_q <= PCPlus2E;
            lat_wd_q  <= fwd_b;
          end
        end
        RUN: begin
          if (flushE) begin
            state_q <= IDLE;
          end else begin
            if (op_q == MD_MUL) begin
              if (b_q[0]) acc_q <= acc_q + a_q;
              a_q <= a_q << 1;
              b_q <= b_q >> 1;
            end else if (rem_shift >= {1'b0, b_q}) begin
              acc_q <= rem_diff;
              a_q   <= {a_q[DATA_W-2:0], 1'b1};
            end else begin
              acc_q <= rem_shift[DATA_W-1:0];
              a_q   <= {a_q[DATA_W-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  assign busy    = 1'b0;
  assign md_done = 1'b0;
  assign md_res  = '0;
  assign md_rw   = 1'b0;
  assign md_mw   = 1'b0;
  assign md_rs   = '0;
  assign md_rd   = '0;
  assign md_pc2  = '0;
  assign md_wd   = '0;
`endif

  logic              reg_write_d, reg_write_q, mem_write_d, mem_write_q;
  logic [1:0]        result_src_d, result_src_q;
  logic [DATA_W-1:0] alu_res_d, alu_res_q, write_data_d, write_data_q, pc_plus2_d, pc_plus2_q;
  logic [RA_W-1:0]   rd_d, rd_q;

  // Bubbles are all-zero so downstream sees deterministic values
  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = '0;
    alu_res_d    = '0;
    write_data_d = '0;
    pc_plus2_d   = '0;
    rd_d         = '0;
    if (!flushE) begin
      if (md_done) begin
        reg_write_d  = md_rw;
        mem_write_d  = md_mw;
        result_src_d = md_rs;
        alu_res_d    = md_res;
        write_data_d = md_wd;
        pc_plus2_d   = md_pc2;
        rd_d         = md_rd;
      end else if (!busy) begin
        reg_write_d  = regWriteE;
        mem_write_d  = memWriteE;
        result_src_d = resultSrcE;
        alu_res_d    = alu_res;
        write_data_d = fwd_b;
        pc_plus2_d   = PCPlus2E;
        rd_d         = RdE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      alu_res_q    <= '0;
      write_data_q <= '0;
      pc_plus2_q   <= '0;
      rd_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      alu_res_q    <= alu_res_d;
      write_data_q <= write_data_d;
      pc_plus2_q   <= pc_plus2_d;
      rd_q         <= rd_d;
    end
  end

  assign regWriteM  = reg_write_q;
  assign memWriteM  = mem_write_q;
  assign resultSrcM = result_src_q;
  assign aluResM    = alu_res_q;
  assign writeDataM = write_data_q;
  assign PCPlus2M   = pc_plus2_q;
  assign RdM        = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage; MUL/DIV vectors run only when EXEC_MULDIV_EN is defined.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWriteE, memWriteE, aluSrcE, branchE, jumpE, flushE;
  logic [1:0]  resultSrcE, fwdAE, fwdBE;
  logic [3:0]  aluCtrlE, RdE;
  logic [15:0] rd1E, rd2E, immExtE, PCE, PCPlus2E, resultW;
  logic        regWriteM, memWriteM, PCSrcE, busyE;
  logic [1:0]  resultSrcM;
  logic [15:0] aluResM, writeDataM, PCPlus2M, PCTargetE;
  logic [3:0]  RdM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage #(.DATA_W(16), .RA_W(4)) dut (
    .clk(clk), .rst(rst),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .resultSrcE(resultSrcE),
    .aluCtrlE(aluCtrlE), .aluSrcE(aluSrcE), .branchE(branchE), .jumpE(jumpE),
    .rd1E(rd1E), .rd2E(rd2E), .immExtE(immExtE), .PCE(PCE), .PCPlus2E(PCPlus2E),
    .RdE(RdE), .fwdAE(fwdAE), .fwdBE(fwdBE), .resultW(resultW), .flushE(flushE),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM),
    .aluResM(aluResM), .writeDataM(writeDataM), .PCPlus2M(PCPlus2M), .RdM(RdM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .busyE(busyE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] ctrl, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic src);
    aluCtrlE  = ctrl;
    rd1E      = a;
    rd2E      = b;
    immExtE   = imm;
    aluSrcE   = src;
    fwdAE     = 2'b00;
    fwdBE     = 2'b00;
    regWriteE = 1'b1;
    memWriteE = 1'b0;
    RdE       = 4'h4;
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] ctrl, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] imm, input logic src,
                         input logic [15:0] exp);
    set_op(ctrl, a, b, imm, src);
    tick();
    check(tag, aluResM, exp);
    check({tag, "_wd"}, writeDataM, b);
    $display("alu %-6s a=%h b=%h imm=%h src=%0d -> %h", tag, a, b, imm, src, aluResM);
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic run_md(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp);
    int busy_cnt;
    logic bub_ok;
    set_op(op, a, b, 16'h0, 1'b0);
    RdE = 4'h5;
    #1;
    busy_cnt = 0;
    bub_ok   = 1'b1;
    while (busyE && busy_cnt < 40) begin
      busy_cnt++;
      tick();
      if (regWriteM !== 1'b0 || memWriteM !== 1'b0) bub_ok = 1'b0;
      if (busy_cnt == 1) begin
        rd1E = 16'h0;
        rd2E = 16'h0;
      end
    end
    check({tag, "_busy"}, busy_cnt, 17);
    check({tag, "_bubbles"}, bub_ok, 1'b1);
    tick();
    check({tag, "_res"}, aluResM, exp);
    check({tag, "_rd"}, RdM, 4'h5);
    check({tag, "_rw"}, regWriteM, 1'b1);
    $display("muldiv %-6s a=%h b=%h busy=%0d -> %h", tag, a, b, busy_cnt, aluResM);
    set_op(4'b0000, 16'h0, 16'h0, 16'h0, 1'b0);
    regWriteE = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flushE = 1'b0; branchE = 1'b0; jumpE = 1'b0;
    resultSrcE = 2'b00; PCE = 16'h0; PCPlus2E = 16'h0; resultW = 16'h0;
    set_op(4'b0000, 16'h0, 16'h0, 16'h0, 1'b0);
    regWriteE = 1'b0;
    #12;
    check("rst_rw", regWriteM, 1'b0);
    check("rst_alu", aluResM, 16'h0);
    check("rst_rd", RdM, 4'h0);
    check("rst_busy", busyE, 1'b0);
    rst = 1'b0;
    tick();

    // ADD, then forwarding from aluResM and resultW
    set_op(4'b0000, 16'h1234, 16'h1111, 16'h0, 1'b0);
    RdE = 4'h3;
    tick();
    check("add_res", aluResM, 16'h2345);
    check("add_rd", RdM, 4'h3);
    check("add_rw", regWriteM, 1'b1);
    $display("alu add    -> %h", aluResM);
    set_op(4'b0001, 16'h0000, 16'h0345, 16'h0, 1'b0);
    fwdAE = 2'b10;
    tick();
    check("fwdA_m", aluResM, 16'h2000);
    set_op(4'b0001, 16'h0005, 16'h0100, 16'h0, 1'b0);
    fwdBE = 2'b01;
    resultW = 16'h0001;
    tick();
    check("fwdB_w", aluResM, 16'h0004);
    check("fwdB_wd", writeDataM, 16'h0001);
    set_op(4'b0000, 16'h0010, 16'h0001, 16'h0, 1'b0);
    fwdAE = 2'b11;
    resultW = 16'h9999;
    tick();
    check("fwdA_11", aluResM, 16'h0011);

    // Branch and jump resolution
    set_op(4'b0001, 16'h00AA, 16'h00AA, 16'hFFF0, 1'b0);
    branchE = 1'b1;
    PCE = 16'h0010;
    #1;
    check("beq_taken", PCSrcE, 1'b1);
    check("beq_target", PCTargetE, 16'h0000);
    rd2E = 16'h00AB;
    #1;
    check("beq_not", PCSrcE, 1'b0);
    jumpE = 1'b1;
    #1;
    check("jump", PCSrcE, 1'b1);
    branchE = 1'b0;
    jumpE = 1'b0;
    rd2E = 16'h00AA;
    #1;
    check("nobranch", PCSrcE, 1'b0);
    tick();

    alu_vec("and",   4'b0010, 16'hF0F0, 16'h0FF0, 16'h0000, 1'b0, 16'h00F0);
    alu_vec("or",    4'b0011, 16'hF0F0, 16'h0FF0, 16'h0000, 1'b0, 16'hFFF0);
    alu_vec("xor",   4'b0100, 16'hF0F0, 16'h0FF0, 16'h0000, 1'b0, 16'hFF00);
    alu_vec("sll",   4'b0101, 16'h0001, 16'h5555, 16'h0014, 1'b1, 16'h0010);
    alu_vec("srl",   4'b0110, 16'h8000, 16'h0003, 16'h0000, 1'b0, 16'h1000);
    alu_vec("sra",   4'b0111, 16'h8000, 16'h0003, 16'h0000, 1'b0, 16'hF000);
    alu_vec("sra2",  4'b0111, 16'h4000, 16'h0012, 16'h0000, 1'b0, 16'h1000);
    alu_vec("slt1",  4'b1000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0001);
    alu_vec("slt0",  4'b1000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16'h0000);
    alu_vec("passb", 4'b1100, 16'h1234, 16'h0007, 16'hBEEF, 1'b1, 16'hBEEF);
    alu_vec("op13",  4'b1101, 16'h1234, 16'h0001, 16'h0000, 1'b0, 16'h0000);
    alu_vec("addov", 4'b0000, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 16'h0001);
    alu_vec("subuf", 4'b0001, 16'h0000, 16'h0001, 16'h0000, 1'b0, 16'hFFFF);

    // Control pass-through
    set_op(4'b0000, 16'h0001, 16'h0001, 16'h0, 1'b0);
    regWriteE = 1'b0; memWriteE = 1'b1; resultSrcE = 2'b10; PCPlus2E = 16'h0042; RdE = 4'hA;
    tick();
    check("pt_mw", memWriteM, 1'b1);
    check("pt_rw", regWriteM, 1'b0);
    check("pt_rs", resultSrcM, 2'b10);
    check("pt_pc2", PCPlus2M, 16'h0042);
    check("pt_rd", RdM, 4'hA);
    resultSrcE = 2'b00;

    // Flush of a single-cycle instruction
    set_op(4'b0000, 16'h0001, 16'h0001, 16'h0, 1'b0);
    memWriteE = 1'b1;
    flushE = 1'b1;
    tick();
    check("flush_rw", regWriteM, 1'b0);
    check("flush_mw", memWriteM, 1'b0);
    flushE = 1'b0;
    memWriteE = 1'b0;
    alu_vec("add2", 4'b0000, 16'h0100, 16'h0023, 16'h0000, 1'b0, 16'h0123);

`ifdef EXEC_MULDIV_EN
    run_md("mul",   4'b1001, 16'h0123, 16'h0010, 16'h1230);
    run_md("divu",  4'b1010, 16'd100,  16'd7,    16'd14);
    run_md("remu",  4'b1011, 16'd100,  16'd7,    16'd2);
    run_md("div0",  4'b1010, 16'h0055, 16'h0000, 16'hFFFF);
    run_md("rem0",  4'b1011, 16'h0055, 16'h0000, 16'h0055);
    run_md("mulbg", 4'b1001, 16'hFFFF, 16'hFFFF, 16'h0001);

    // Flush in RUN cycle 5
    begin
      logic quiet;
      set_op(4'b1001, 16'h0123, 16'h0010, 16'h0, 1'b0);
      RdE = 4'h6;
      tick();
      repeat (4) tick();
      flushE = 1'b1;
      #1;
      check("fl_busy_run", busyE, 1'b1);
      tick();
      flushE = 1'b0;
      set_op(4'b0000, 16'h0007, 16'h0001, 16'h0, 1'b0);
      RdE = 4'h2;
      #1;
      check("fl_busy_drop", busyE, 1'b0);
      check("fl_bubble", regWriteM, 1'b0);
      tick();
      check("fl_add", aluResM, 16'h0008);
      check("fl_add_rd", RdM, 4'h2);
      set_op(4'b0000, 16'h0, 16'h0, 16'h0, 1'b0);
      regWriteE = 1'b0;
      quiet = 1'b1;
      repeat (20) begin
        tick();
        if (regWriteM !== 1'b0 || aluResM !== 16'h0 || busyE !== 1'b0) quiet = 1'b0;
      end
      check("fl_no_result", quiet, 1'b1);
      $display("muldiv flush in RUN cycle 5 done");
    end

    // Async reset in RUN cycle 8
    alu_vec("add3", 4'b0000, 16'h0002, 16'h0003, 16'h0000, 1'b0, 16'h0005);
    set_op(4'b1001, 16'h0123, 16'h0010, 16'h0, 1'b0);
    RdE = 4'h7;
    tick();
    repeat (7) tick();
    #1;
    rst = 1'b1;
    #1;
    check("ar_rw", regWriteM, 1'b0);
    check("ar_alu", aluResM, 16'h0);
    check("ar_rd", RdM, 4'h0);
    check("ar_wd", writeDataM, 16'h0);
    #1;
    rst = 1'b0;
    run_md("mul_ar", 4'b1001, 16'h0123, 16'h0010, 16'h1230);
`else
    set_op(4'b1001, 16'h0003, 16'h0005, 16'h0, 1'b0);
    #1;
    check("nomd_busy", busyE, 1'b0);
    tick();
    check("nomd_mul", aluResM, 16'h0000);
    check("nomd_rw", regWriteM, 1'b1);
    set_op(4'b1010, 16'h0064, 16'h0007, 16'h0, 1'b0);
    tick();
    check("nomd_div", aluResM, 16'h0000);
    $display("muldiv disabled: mul/div give 0 in one cycle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
